// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-ramp sequencer and the PWM core.
package pwm_pkg;

  localparam int DUTY_W_DEF  = 8;
  localparam int STEP_W_DEF  = 4;
  localparam int DWELL_W_DEF = 8;

  // Working width of clamp_step; callers zero-extend narrower operands.
  localparam int CLAMP_W = 16;

  // Level of the period-end strobe as driven by the PWM core.
  localparam logic PERIOD_STROBE_ACTIVE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  // Move duty toward target by at most step, landing exactly on target.
  function automatic logic [CLAMP_W-1:0] clamp_step(
    input logic [CLAMP_W-1:0] duty,
    input logic [CLAMP_W-1:0] target,
    input logic [CLAMP_W-1:0] step
  );
    logic signed [CLAMP_W:0] diff;
    logic        [CLAMP_W-1:0] mag;
    logic        [CLAMP_W-1:0] delta;
    diff  = $signed({1'b0, target}) - $signed({1'b0, duty});
    mag   = diff[CLAMP_W] ? CLAMP_W'(-diff) : CLAMP_W'(diff);
    delta = (step < mag) ? step : mag;
    return diff[CLAMP_W] ? (duty - delta) : (duty + delta);
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl.sv
// Command-driven duty sequencer: ramps PWM duty toward a target one clamped
// step per PWM period, holds for a dwell count, then pulses done.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int STEP_W  = STEP_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DUTY_W-1:0]  cmd_target,
  input  logic [STEP_W-1:0]  cmd_step,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  input  logic               period_end,
  output logic [DUTY_W-1:0]  duty_out,
  output logic               duty_load,
  output logic               busy,
  output logic               done
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [DUTY_W-1:0]    r_duty;
  logic [DUTY_W-1:0]    r_target;
  logic [STEP_W-1:0]    r_step;
  logic [DWELL_W-1:0]   r_dwell;
  logic [DWELL_W-1:0]   r_cnt;
  logic                 r_load;
  logic                 r_done;

  logic                 w_pe;
  logic                 w_accept;
  logic signed [DUTY_W:0] w_diff;
  logic                 w_diff_zero;
  logic [DUTY_W-1:0]    w_duty_step;
  logic                 w_duty_upd;
  logic                 w_load_nxt;
  logic                 w_done_nxt;
  logic                 w_cnt_load;
  logic                 w_cnt_dec;

  // Strobes seen while disabled are dropped, not deferred.
  assign w_pe        = (period_end == PERIOD_STROBE_ACTIVE) && ena;
  assign w_diff      = $signed({1'b0, r_target}) - $signed({1'b0, r_duty});
  assign w_diff_zero = (w_diff == '0);
  assign w_duty_step = DUTY_W'(clamp_step(CLAMP_W'(r_duty), CLAMP_W'(r_target),
                                          CLAMP_W'(r_step)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort outranks a same-cycle period_end.
  always_comb begin
    w_state_nxt = r_state;
    if (ena) begin
      unique case (r_state)
        ST_IDLE:  if (cmd_valid) w_state_nxt = ST_RAMP;
        ST_RAMP: begin
          if (abort)                     w_state_nxt = ST_IDLE;
          else if (w_pe && w_diff_zero)  w_state_nxt = (r_dwell == '0) ? ST_IDLE : ST_DWELL;
        end
        ST_DWELL: begin
          if (abort)                                 w_state_nxt = ST_IDLE;
          else if (w_pe && r_cnt == DWELL_W'(1))     w_state_nxt = ST_IDLE;
        end
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath and strobe controls decoded from state and inputs.
  always_comb begin
    w_accept   = 1'b0;
    w_duty_upd = 1'b0;
    w_load_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    if (ena) begin
      unique case (r_state)
        ST_IDLE: w_accept = cmd_valid;
        ST_RAMP: begin
          if (!abort && w_pe) begin
            if (!w_diff_zero) begin
              w_duty_upd = 1'b1;
              w_load_nxt = 1'b1;
            end else if (r_dwell == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_cnt_load = 1'b1;
            end
          end
        end
        ST_DWELL: begin
          if (!abort && w_pe) begin
            w_cnt_dec  = 1'b1;
            w_done_nxt = (r_cnt == DWELL_W'(1));
          end
        end
        default: ;
      endcase
    end
  end

  // Duty value, one-cycle strobes and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
      r_load <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_load <= w_load_nxt;
      r_done <= w_done_nxt;
      if (w_duty_upd) r_duty <= w_duty_step;
      if (w_cnt_load)     r_cnt <= r_dwell;
      else if (w_cnt_dec) r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

  // Command fields latched on accept; a zero step means one.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_target <= cmd_target;
      r_step   <= (cmd_step == '0) ? STEP_W'(1) : cmd_step;
      r_dwell  <= cmd_dwell;
    end
  end

  assign cmd_ready = ena && (r_state == ST_IDLE);
  assign duty_out  = r_duty;
  assign duty_load = r_load && ena;
  assign done      = r_done && ena;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed, table-driven bench for pwm_ramp_ctrl.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_target;
  logic [3:0] cmd_step;
  logic [7:0] cmd_dwell;
  logic       abort;
  logic       period_end;
  logic [7:0] duty_out;
  logic       duty_load;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic       cv;
    logic [7:0] tg;
    logic [3:0] st;
    logic [7:0] dw;
    logic       ab;
    logic       pe;
    logic       en;
    logic [7:0] e_duty;
    logic       e_load;
    logic       e_busy;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  vec_t tbl[$];

  pwm_ramp_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .cmd_dwell  (cmd_dwell),
    .abort      (abort),
    .period_end (period_end),
    .duty_out   (duty_out),
    .duty_load  (duty_load),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] ed, input logic el,
                         input logic eb, input logic edn, input logic er);
    chk({nm, ".duty"},  int'(duty_out),  int'(ed));
    chk({nm, ".load"},  int'(duty_load), int'(el));
    chk({nm, ".busy"},  int'(busy),      int'(eb));
    chk({nm, ".done"},  int'(done),      int'(edn));
    chk({nm, ".ready"}, int'(cmd_ready), int'(er));
  endtask

  function automatic void row(input string nm, input logic cv, input logic [7:0] tg,
                              input logic [3:0] st, input logic [7:0] dw, input logic ab,
                              input logic pe, input logic en, input logic [7:0] ed,
                              input logic el, input logic eb, input logic edn, input logic er);
    vec_t v;
    v.nm = nm; v.cv = cv; v.tg = tg; v.st = st; v.dw = dw; v.ab = ab; v.pe = pe; v.en = en;
    v.e_duty = ed; v.e_load = el; v.e_busy = eb; v.e_done = edn; v.e_ready = er;
    tbl.push_back(v);
  endfunction

  // Shorthand: command accept row (duty unchanged, busy next cycle).
  function automatic void acc(input string nm, input logic [7:0] tg, input logic [3:0] st,
                              input logic [7:0] dw, input logic [7:0] cur);
    row(nm, 1'b1, tg, st, dw, 1'b0, 1'b0, 1'b1, cur, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  // Shorthand: a period_end strobe with ena=1.
  function automatic void pe_row(input string nm, input logic [7:0] ed, input logic el,
                                 input logic eb, input logic edn, input logic er);
    row(nm, 1'b0, 8'd0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, ed, el, eb, edn, er);
  endfunction

  // Shorthand: a quiet cycle with ena=1.
  function automatic void q_row(input string nm, input logic [7:0] ed, input logic el,
                                input logic eb, input logic edn, input logic er);
    row(nm, 1'b0, 8'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, ed, el, eb, edn, er);
  endfunction

  task automatic run_table();
    foreach (tbl[i]) begin
      @(negedge clk);
      cmd_valid  = tbl[i].cv;
      cmd_target = tbl[i].tg;
      cmd_step   = tbl[i].st;
      cmd_dwell  = tbl[i].dw;
      abort      = tbl[i].ab;
      period_end = tbl[i].pe;
      ena        = tbl[i].en;
      @(posedge clk);
      #1;
      chk_all(tbl[i].nm, tbl[i].e_duty, tbl[i].e_load, tbl[i].e_busy,
              tbl[i].e_done, tbl[i].e_ready);
    end
    tbl.delete();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0;
    cmd_dwell = '0; abort = 1'b0; period_end = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.duty", int'(duty_out), 0);
    chk("rst.load", int'(duty_load), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel.ready", int'(cmd_ready), 1);

    // Up-ramp 0 -> 10, step 4, dwell 2.
    acc("up_acc", 8'd10, 4'd4, 8'd2, 8'd0);
    pe_row("up_s1", 8'd4, 1, 1, 0, 0);
    q_row ("up_g1", 8'd4, 0, 1, 0, 0);
    pe_row("up_s2", 8'd8, 1, 1, 0, 0);
    q_row ("up_g2", 8'd8, 0, 1, 0, 0);
    pe_row("up_s3", 8'd10, 1, 1, 0, 0);
    q_row ("up_g3", 8'd10, 0, 1, 0, 0);
    pe_row("up_eq", 8'd10, 0, 1, 0, 0);
    pe_row("up_dw1", 8'd10, 0, 1, 0, 0);
    pe_row("up_dw2", 8'd10, 0, 0, 1, 1);
    q_row ("up_post", 8'd10, 0, 0, 0, 1);

    // Down-ramp 10 -> 0 with step 0 (acts as 1), dwell 0.
    acc("dn_acc", 8'd0, 4'd0, 8'd0, 8'd10);
    for (int k = 1; k <= 10; k++) pe_row($sformatf("dn_s%0d", k), 8'(10 - k), 1, 1, 0, 0);
    pe_row("dn_eq", 8'd0, 0, 0, 1, 1);
    q_row ("dn_post", 8'd0, 0, 0, 0, 1);

    // Climb to 250 with step 15, then 250 -> 255 in a single clamped step.
    acc("sat_acc1", 8'd250, 4'd15, 8'd0, 8'd0);
    for (int k = 1; k <= 16; k++) pe_row($sformatf("sat_c%0d", k), 8'(15 * k), 1, 1, 0, 0);
    pe_row("sat_c17", 8'd250, 1, 1, 0, 0);
    pe_row("sat_eq1", 8'd250, 0, 0, 1, 1);
    acc("sat_acc2", 8'd255, 4'd15, 8'd1, 8'd250);
    pe_row("sat_top", 8'd255, 1, 1, 0, 0);
    pe_row("sat_eq2", 8'd255, 0, 1, 0, 0);
    pe_row("sat_dw", 8'd255, 0, 0, 1, 1);

    // Start a ramp down so reset lands mid-RAMP.
    acc("mid_acc", 8'd0, 4'd1, 8'd0, 8'd255);
    pe_row("mid_s1", 8'd254, 1, 1, 0, 0);
    run_table();

    // Asynchronous reset mid-RAMP: outputs clear before any clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.duty", int'(duty_out), 0);
    chk("rst_mid.load", int'(duty_load), 0);
    chk("rst_mid.busy", int'(busy), 0);
    chk("rst_mid.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_rel.ready", int'(cmd_ready), 1);
    chk("rst_mid_rel.busy", int'(busy), 0);

    // Abort mid-RAMP with a same-cycle period_end.
    acc("ab_acc", 8'd200, 4'd8, 8'd0, 8'd0);
    pe_row("ab_s1", 8'd8, 1, 1, 0, 0);
    pe_row("ab_s2", 8'd16, 1, 1, 0, 0);
    row("ab_hit", 0, 8'd0, 4'd0, 8'd0, 1, 1, 1, 8'd16, 0, 0, 0, 1);
    q_row("ab_post", 8'd16, 0, 0, 0, 1);

    // Abort in IDLE is ignored and the simultaneous command is taken.
    row("ab_idle_acc", 1, 8'd100, 4'd5, 8'd0, 1, 0, 1, 8'd16, 0, 1, 0, 0);
    pe_row("en_s1", 8'd21, 1, 1, 0, 0);

    // ena=0 drops three strobes; ramp resumes after re-enable.
    for (int k = 0; k < 3; k++)
      row($sformatf("en0_%0d", k), 0, 8'd0, 4'd0, 8'd0, 0, 1, 0, 8'd21, 0, 1, 0, 0);
    q_row ("en1_q", 8'd21, 0, 1, 0, 0);
    pe_row("en1_s", 8'd26, 1, 1, 0, 0);

    // Abort out of DWELL gives no done.
    row("dw_ab0", 0, 8'd0, 4'd0, 8'd0, 1, 0, 1, 8'd26, 0, 0, 0, 1);
    acc("dw_acc", 8'd26, 4'd3, 8'd3, 8'd26);
    pe_row("dw_eq", 8'd26, 0, 1, 0, 0);
    pe_row("dw_c1", 8'd26, 0, 1, 0, 0);
    row("dw_ab", 0, 8'd0, 4'd0, 8'd0, 1, 0, 1, 8'd26, 0, 0, 0, 1);
    q_row("dw_post", 8'd26, 0, 0, 0, 1);

    // Disabled block refuses commands.
    row("en0_idle", 1, 8'd50, 4'd1, 8'd0, 0, 0, 0, 8'd26, 0, 0, 0, 0);
    q_row("en0_idle_post", 8'd26, 0, 0, 0, 1);
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
